// File: rtl/alu_pkg.sv
// Shared op-code encodings, FSM states and op-class decode
// for the sequential mul/div EX-stage ALU.
package alu_pkg;

    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MUL,
        CLS_DIV,
        CLS_ILL
    } op_class_t;

    function automatic op_class_t op_class(input logic [5:0] op);
        op_class_t c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
            OP_SLT, OP_SLL, OP_SRL, OP_SRA,
            OP_MFHI, OP_MFLO:   c = CLS_ALU;
            OP_MULT, OP_MULTU:  c = CLS_MUL;
            OP_DIV, OP_DIVU:    c = CLS_DIV;
            default:            c = CLS_ILL;
        endcase
        return c;
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider on
// operand magnitudes, with sign fix applied to the final step.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             is_div,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    logic               run;
    logic               mode_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               zdiv;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   a_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [2*WIDTH-1:0] prod_n;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     sh;
    logic [WIDTH:0]     dif;
    logic               ge;
    logic [WIDTH-1:0]   rem_n;
    logic [WIDTH-1:0]   quo_n;
    logic [2*WIDTH-1:0] full;

    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // One iteration of either engine, then sign fix of the would-be result
    always_comb begin
        prod_n = prod;
        sum    = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            sum    = {1'b0, prod_n[2*WIDTH-1:WIDTH]}
                   + (prod_n[0] ? {1'b0, dvs} : '0);
            prod_n = {sum, prod_n[WIDTH-1:1]};
        end
        sh    = {rem, quo[WIDTH-1]};
        dif   = sh - {1'b0, dvs};
        ge    = (sh >= {1'b0, dvs});
        rem_n = ge ? dif[WIDTH-1:0] : sh[WIDTH-1:0];
        quo_n = {quo[WIDTH-2:0], ge};
        full  = neg_lo ? -prod_n : prod_n;
        if (mode_div) begin
            if (zdiv) begin
                lo = '1;
                hi = a_q;
            end else begin
                lo = neg_lo ? -quo_n : quo_n;
                hi = neg_hi ? -rem_n : rem_n;
            end
        end else begin
            lo = full[WIDTH-1:0];
            hi = full[2*WIDTH-1:WIDTH];
        end
    end

    assign fin = run && (cnt == (mode_div ? DIV_LAST : MUL_LAST));
    assign dbz = mode_div & zdiv;

    // Operand load on go, then one step per clock until the last count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            mode_div <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            zdiv     <= 1'b0;
            cnt      <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            a_q      <= '0;
        end else if (go) begin
            run      <= 1'b1;
            mode_div <= is_div;
            cnt      <= '0;
            a_q      <= a;
            zdiv     <= is_div && (b == '0);
            if (is_div) begin
                rem    <= '0;
                quo    <= a_mag;
                dvs    <= b_mag;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg;
            end else begin
                prod   <= {{WIDTH{1'b0}}, b_mag};
                dvs    <= a_mag;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg ^ b_neg;
            end
        end else if (run) begin
            cnt <= cnt + 1'b1;
            if (mode_div) begin
                rem <= rem_n;
                quo <= quo_n;
            end else begin
                prod <= prod_n;
            end
            if (fin) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// EX-stage ALU: single-cycle ops plus iterative mul/div into
// HI/LO, behind a Start/Busy/Done handshake.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivByZero,
    output logic             IllegalOp
);

    localparam int SW = $clog2(WIDTH);

    state_t           state;
    op_class_t        cls;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;
    logic             sc_ill;
    logic [SW-1:0]    shamt;
    logic             idle;
    logic             go;
    logic             m_fin;
    logic             m_dbz;
    logic [WIDTH-1:0] m_hi;
    logic [WIDTH-1:0] m_lo;

    assign cls   = op_class(ALUControl);
    assign shamt = B[SW-1:0];
    assign idle  = (state == IDLE) || (state == FIN);
    assign go    = Start && idle
                && ((cls == CLS_MUL) || (cls == CLS_DIV));

    // Single-cycle result and flags for the requested op
    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                sc_res = A + B;
                sc_ovf = (A[WIDTH-1] == B[WIDTH-1])
                      && (sc_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = A - B;
                sc_ovf = (A[WIDTH-1] != B[WIDTH-1])
                      && (sc_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_XOR:  sc_res = A ^ B;
            OP_NOR:  sc_res = ~(A | B);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                               ($signed(A) < $signed(B))};
            OP_SLL:  sc_res = A << shamt;
            OP_SRL:  sc_res = A >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(A) >>> shamt);
            OP_MFHI: sc_res = hi;
            OP_MFLO: sc_res = lo;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: sc_res = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    // Control FSM with registered handshake, result, flags and HI/LO
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            DivByZero <= 1'b0;
            IllegalOp <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    state <= IDLE;
                    if (Start) begin
                        case (cls)
                            CLS_MUL: begin
                                state <= MUL;
                                Busy  <= 1'b1;
                            end
                            CLS_DIV: begin
                                state <= DIV;
                                Busy  <= 1'b1;
                            end
                            default: begin
                                Done      <= 1'b1;
                                ALUResult <= sc_res;
                                Zero      <= (sc_res == '0);
                                Overflow  <= sc_ovf;
                                DivByZero <= 1'b0;
                                IllegalOp <= sc_ill;
                            end
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (m_fin) begin
                        state     <= FIN;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        hi        <= m_hi;
                        lo        <= m_lo;
                        ALUResult <= m_lo;
                        Zero      <= (m_lo == '0);
                        Overflow  <= 1'b0;
                        DivByZero <= m_dbz;
                        IllegalOp <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    alu_muldiv_iter #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_iter (
        .clk    (Clk),
        .rst_n  (Rst),
        .go     (go),
        .is_div (cls == CLS_DIV),
        .sgn    (op_signed(ALUControl)),
        .a      (A),
        .b      (B),
        .fin    (m_fin),
        .hi     (m_hi),
        .lo     (m_lo),
        .dbz    (m_dbz)
    );

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv: directed vectors push
// expectations, a negedge monitor pops and compares on Done.
module tb_alu_seq_muldiv;
    import alu_pkg::*;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        d;
        logic        i;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        Rst;
    logic        Start;
    logic [5:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Overflow;
    logic        DivByZero;
    logic        IllegalOp;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   next_id = 0;

    alu_seq_muldiv #(
        .WIDTH    (32),
        .MUL_STEP (1)
    ) dut (
        .Clk        (clk),
        .Rst        (Rst),
        .Start      (Start),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .Busy       (Busy),
        .Done       (Done),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Overflow   (Overflow),
        .DivByZero  (DivByZero),
        .IllegalOp  (IllegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (Rst && Done) begin
            n_chk++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: cyc=%0d res=%h required no Done",
                         cyc, ALUResult);
            end else begin
                e = sbq.pop_front();
                if ({ALUResult, Zero, Overflow, DivByZero, IllegalOp, Busy}
                        !== {e.res, e.z, e.o, e.d, e.i, 1'b0}
                        || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL op%0d: got res=%h z%b o%b d%b i%b busy%b cyc%0d required res=%h z%b o%b d%b i%b busy0 cyc%0d",
                             e.id, ALUResult, Zero, Overflow, DivByZero,
                             IllegalOp, Busy, cyc, e.res, e.z, e.o,
                             e.d, e.i, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res,
                         input logic z, input logic o, input logic d,
                         input logic il, input int lat, input bit push);
        exp_t e;
        ALUControl = op;
        A = a;
        B = b;
        Start = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e = '{next_id, res, z, o, d, il, cyc + lat - 1};
            sbq.push_back(e);
        end
        next_id++;
        Start = 1'b0;
    endtask

    task automatic wait_done(output int nb);
        bit ok;
        nb = 0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (Done) begin
                ok = 1;
                break;
            end
            if (Busy) nb++;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: no Done within 200 cycles");
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res,
                       input logic z, input logic o, input logic d,
                       input logic il, input int lat);
        int nb;
        issue(op, a, b, res, z, o, d, il, lat, 1'b1);
        wait_done(nb);
        chk("busy_cycles", 64'(nb), 64'(lat - 1));
    endtask

    initial begin
        int nb;
        int cd;
        Rst = 1'b0;
        Start = 1'b0;
        ALUControl = '0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs",
            64'({Busy, Done, ALUResult, Zero, Overflow, DivByZero, IllegalOp}),
            64'(0));
        Rst = 1'b1;
        @(negedge clk);

        run(OP_ADD,  32'h7fffffff, 32'h1,        32'h80000000, 0, 1, 0, 0, 1);
        run(OP_SUB,  32'ha,        32'ha,        32'h0,        1, 0, 0, 0, 1);
        run(OP_SUB,  32'h80000000, 32'h1,        32'h7fffffff, 0, 1, 0, 0, 1);
        run(OP_AND,  32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 0, 0, 0, 0, 1);
        run(OP_OR,   32'hf0f0f0f0, 32'hff00ff00, 32'hfff0fff0, 0, 0, 0, 0, 1);
        run(OP_XOR,  32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 0, 0, 0, 0, 1);
        run(OP_NOR,  32'h0,        32'h0,        32'hffffffff, 0, 0, 0, 0, 1);
        run(OP_SLT,  32'hffffffff, 32'h1,        32'h1,        0, 0, 0, 0, 1);
        run(OP_SLT,  32'h1,        32'hffffffff, 32'h0,        1, 0, 0, 0, 1);
        run(OP_SLL,  32'h1,        32'h22,       32'h4,        0, 0, 0, 0, 1);
        run(OP_SRL,  32'h80000000, 32'h4,        32'h08000000, 0, 0, 0, 0, 1);
        run(OP_SRA,  32'h80000000, 32'h4,        32'hf8000000, 0, 0, 0, 0, 1);

        run(OP_MULT, 32'hfffffffe, 32'h3,        32'hfffffffa, 0, 0, 0, 0, 33);
        run(OP_MFHI, 32'h0,        32'h0,        32'hffffffff, 0, 0, 0, 0, 1);
        run(OP_MFLO, 32'h0,        32'h0,        32'hfffffffa, 0, 0, 0, 0, 1);

        run(OP_DIV,  32'hfffffff9, 32'h2,        32'hfffffffd, 0, 0, 0, 0, 33);
        run(OP_MFHI, 32'h0,        32'h0,        32'hffffffff, 0, 0, 0, 0, 1);
        run(OP_DIVU, 32'h7,        32'h0,        32'hffffffff, 0, 0, 1, 0, 33);
        run(OP_MFHI, 32'h0,        32'h0,        32'h7,        0, 0, 0, 0, 1);
        run(OP_ILL_CODE(), 32'h5,  32'h6,        32'h0,        1, 0, 0, 1, 1);
        run(OP_DIV,  32'h80000000, 32'hffffffff, 32'h80000000, 0, 0, 0, 0, 33);
        run(OP_MFHI, 32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 1);
        run(OP_DIVU, 32'd100,      32'd7,        32'd14,       0, 0, 0, 0, 33);
        run(OP_MFHI, 32'h0,        32'h0,        32'd2,        0, 0, 0, 0, 1);

        issue(OP_MULTU, 32'h10000, 32'h10000, 32'h0, 1, 0, 0, 0, 33, 1'b1);
        repeat (5) @(negedge clk);
        ALUControl = OP_ADD;
        A = 32'h1;
        B = 32'h1;
        Start = 1'b1;
        repeat (3) @(negedge clk);
        Start = 1'b0;
        wait_done(nb);
        chk("drop_busy", 64'(nb), 64'(24));
        run(OP_MFHI, 32'h0, 32'h0, 32'h1, 0, 0, 0, 0, 1);

        issue(OP_MULTU, 32'd5, 32'd6, 32'd30, 0, 0, 0, 0, 33, 1'b1);
        wait_done(nb);
        cd = cyc;
        issue(OP_ADD, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1, 1'b1);
        wait_done(nb);
        chk("b2b_gap", 64'(cyc - cd), 64'(1));

        issue(OP_DIV, 32'd100, 32'd3, 32'd33, 0, 0, 0, 0, 33, 1'b0);
        repeat (9) @(negedge clk);
        #2;
        Rst = 1'b0;
        #1;
        chk("rst_mid_div",
            64'({Busy, Done, ALUResult, Zero, Overflow, DivByZero, IllegalOp}),
            64'(0));
        @(negedge clk);
        Rst = 1'b1;
        repeat (40) @(negedge clk);
        run(OP_MFHI, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 1);
        run(OP_MFLO, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 1);

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    function automatic logic [5:0] OP_ILL_CODE();
        return 6'b111111;
    endfunction

endmodule
